y_alu_seq: RTL and testbench
============================

# y_alu_seq

Parametrised, handshaked successor to the 32-bit combinational ALU. It takes one operation per transaction over a valid/ready input port. Results come back through a registered valid/ready output port with zero, overflow and error flags. It adds signed/unsigned set-less-than and an iterative shift-add multiply, and sits between the register-read stage and writeback of the multi-cycle datapath.

## Interface
- WIDTH, 32, operand/result width in bits; legal range 4..64.
- MUL_EN, 1, 1 implements op 100 (multiply); 0 makes op 100 illegal (treated like 101).

- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clk.
- in_valid  in  1  a/b/op valid this cycle.
- in_ready  out  1  block accepts a transaction this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (signed), 011 SLTU, 100 MUL (low WIDTH bits), 101 illegal.
- out_valid  out  1  z/flags valid; held until consumed.
- out_ready  in  1  consumer takes result this cycle.
- z  out  WIDTH  result.
- zero  out  1  z == 0.
- ovf  out  1  signed overflow (ADD/SUB) or unsigned product overflow (MUL); 0 otherwise.
- err  out  1  op was illegal.

## Operation
- Transfer on input when in_valid && in_ready at a rising edge (accept). Transfer on output when out_valid && out_ready (consume).
- FSM states: IDLE, BUSY (multiply iterating), DONE (result held). Reset → IDLE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). Back-to-back accept-while-consume is allowed.
- out_valid = (state==DONE).
- Accept of a single-cycle op (any op except legal MUL) → DONE, with z/flags registered from the accepted a, b, op.
- Accept of MUL → BUSY. Latch a, b, clear accumulator and counter.
  - Each BUSY cycle: if multiplier LSB set, add the shifted multiplicand into a 2*WIDTH accumulator; shift; increment counter.
  - After WIDTH iterations → DONE, with z = acc[WIDTH-1:0] and ovf = |acc[2*WIDTH-1:WIDTH].
- DONE with consume and no accept → IDLE. DONE with consume and accept → DONE or BUSY per the new op.
- Arithmetic:
  - ADD/SUB are modulo 2^WIDTH. ovf = operand signs agree (for SUB, after inverting b) and result sign differs.
  - SLT: z = {0…, a <s b}. SLTU: z = {0…, a <u b}.
  - AND/OR/SLT/SLTU/illegal force ovf=0.
  - Illegal op: z=0, zero=1, err=1; otherwise err=0.
- zero is computed from the registered z.
- Inputs a/b/op are ignored when not accepted. Changing them while BUSY has no effect.

## Timing
- Reset values: in_ready=1, out_valid=0, z=0, zero=0, ovf=0, err=0. State IDLE, accumulator/counter cleared.
- Single-cycle op latency: accept at edge k, then out_valid=1 from edge k to the consuming edge.
- MUL latency: accept at edge k, BUSY for WIDTH cycles, out_valid=1 from edge k+WIDTH. in_ready=0 throughout BUSY.
- Result stability: z/zero/ovf/err do not change while out_valid && !out_ready (backpressure holds indefinitely).
- Peak throughput for single-cycle ops: one per cycle with out_ready tied high.
- Reset mid-operation (BUSY or DONE): the operation is abandoned. Next cycle shows reset values and no spurious out_valid.
- Reset wins over a simultaneous accept.
- in_valid with in_ready=0 is not an accept; the source must hold its values.

## Test plan
- Reset then idle: assert reset 2 cycles → in_ready=1, out_valid=0, z=0, err=0; no output for 10 idle cycles.
- WIDTH=32, out_ready=1, ops streamed every cycle: a=0xFFFF_FFFF, b=1 ADD → z=0, zero=1, ovf=0. a=0x7FFF_FFFF, b=1 ADD → z=0x8000_0000, ovf=1. a=0x8000_0000, b=1 SUB → z=0x7FFF_FFFF, ovf=1. a=0xFFFF_FFFF, b=1 SLT → z=1; SLTU → z=0. AND/OR against a software model for 200 $random pairs, one result per cycle.
- MUL WIDTH=32: a=0x0001_0000, b=0x0001_0000 → out_valid exactly 32 cycles after accept, z=0, zero=1, ovf=1. a=1234, b=5678 → z=7006652, ovf=0. in_ready=0 during all 32 BUSY cycles.
- Backpressure: out_ready=0 for 5 cycles after an ADD result → z/flags held constant, in_ready=0. Raise out_ready with in_valid=1 → consume and accept on the same edge, next result valid the following cycle.
- Illegal op and MUL_EN=0: op=101 → z=0, zero=1, err=1, one-cycle latency. With MUL_EN=0, op=100 gives the same response.
- Parameter and reset sweep: WIDTH=8, a=0x0F, b=0x11 MUL → z=0xFF, ovf=0 after 8 cycles. Reset asserted at BUSY cycle 3 → out_valid never rises for that op; in_ready=1 the cycle after reset is released.

Source files
------------

// File: rtl/y_alu_seq_if.sv
// ---------------------------------------------------------------------------
// y_alu_seq_if
//
// Handshake bundle for the sequential ALU: one valid/ready input channel
// carrying an operation, one valid/ready output channel carrying the result.
//
// Parameters:
//   WIDTH      operand / result width in bits
//
// Signals:
//   in_valid   source has a/b/op valid this cycle
//   in_ready   ALU can accept a transaction this cycle
//   a, b       operands
//   op         operation code (3 bits)
//   out_valid  z and flags are valid and held until consumed
//   out_ready  consumer takes the result this cycle
//   z          result
//   zero       z == 0
//   ovf        signed add/sub overflow or unsigned product overflow
//   err        operation was illegal
//
// Modports:
//   slave      the ALU itself (receives operations, produces results)
//   master     the surrounding datapath (issues operations, takes results)
// ---------------------------------------------------------------------------
interface y_alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] z;
    logic             zero;
    logic             ovf;
    logic             err;

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, z, zero, ovf, err
    );

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, z, zero, ovf, err
    );
endinterface

// File: rtl/y_alu_seq.sv
// ---------------------------------------------------------------------------
// y_alu_seq
//
// Handshaked ALU sitting between register read and writeback. Single-cycle
// ops (AND, OR, ADD, SUB, SLT, SLTU) produce a registered result the edge
// they are accepted; MUL runs an iterative shift-add over WIDTH cycles.
//
// Parameters:
//   WIDTH      operand/result width, 4..64
//   MUL_EN     1 implements op 100 (multiply); 0 treats it as illegal
//
// Ports:
//   clk        single clock, all state changes on the rising edge
//   reset      synchronous active-high reset
//   bus        y_alu_seq_if slave modport (input and output handshakes)
//
// Op codes:
//   000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 011 SLTU, 100 MUL,
//   101 illegal
// ---------------------------------------------------------------------------
module y_alu_seq #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    y_alu_seq_if.slave     bus
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SLTU = 3'b011;
    localparam logic [2:0] OP_MUL  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t             state;

    // Multiplier datapath: multiplicand shifts left inside a double-width
    // register, multiplier shifts right so its LSB selects each partial sum.
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplr;
    logic [CW-1:0]      cnt;

    logic               accept;
    logic               is_mul;
    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH-1:0]   sc_z;
    logic               sc_ovf;
    logic               sc_err;
    logic [2*WIDTH-1:0] acc_next;
    logic               last_iter;

    // A slot frees up either when idle or when the held result is being
    // consumed this very cycle, which allows accept-while-consume.
    assign bus.in_ready  = (state == IDLE) || ((state == DONE) && bus.out_ready);
    assign bus.out_valid = (state == DONE);

    assign accept = bus.in_valid && bus.in_ready;
    assign is_mul = MUL_EN && (bus.op == OP_MUL);

    // Single-cycle result. A legal MUL also lands in the default branch
    // here, but its values are never used because it goes to BUSY instead.
    always_comb begin
        sum    = bus.a + bus.b;
        diff   = bus.a - bus.b;
        sc_z   = '0;
        sc_ovf = 1'b0;
        sc_err = 1'b0;
        case (bus.op)
            OP_AND: sc_z = bus.a & bus.b;
            OP_OR:  sc_z = bus.a | bus.b;
            OP_ADD: begin
                sc_z   = sum;
                sc_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                         (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                // Subtraction overflows when the operands' signs differ
                // (i.e. agree once b is negated) and the result flips sign.
                sc_z   = diff;
                sc_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                         (diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SLT:  sc_z = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_SLTU: sc_z = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            default: sc_err = 1'b1;
        endcase
    end

    // One shift-add step; on the final step this value is the full product,
    // so it is used directly for the registered result.
    assign acc_next  = mplr[0] ? (acc + mcand) : acc;
    assign last_iter = (cnt == CW'(WIDTH - 1));

    // Control FSM plus multiplier datapath and registered result/flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            acc      <= '0;
            mcand    <= '0;
            mplr     <= '0;
            cnt      <= '0;
            bus.z    <= '0;
            bus.zero <= 1'b0;
            bus.ovf  <= 1'b0;
            bus.err  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        if (is_mul) begin
                            state <= BUSY;
                            acc   <= '0;
                            mcand <= {{WIDTH{1'b0}}, bus.a};
                            mplr  <= bus.b;
                            cnt   <= '0;
                        end else begin
                            state    <= DONE;
                            bus.z    <= sc_z;
                            bus.zero <= (sc_z == '0);
                            bus.ovf  <= sc_ovf;
                            bus.err  <= sc_err;
                        end
                    end else if ((state == DONE) && bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    acc   <= acc_next;
                    mcand <= mcand << 1;
                    mplr  <= mplr >> 1;
                    cnt   <= cnt + CW'(1);
                    if (last_iter) begin
                        state    <= DONE;
                        bus.z    <= acc_next[WIDTH-1:0];
                        bus.zero <= (acc_next[WIDTH-1:0] == '0);
                        bus.ovf  <= |acc_next[2*WIDTH-1:WIDTH];
                        bus.err  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_y_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_y_alu_seq
//
// Self-checking bench for y_alu_seq. Three instances: a 32-bit ALU with
// multiply, an 8-bit ALU with multiply, and an 8-bit ALU with multiply
// disabled. Single-cycle ops come from a directed vector table streamed one
// per cycle; multiply, backpressure and reset are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_y_alu_seq;

    logic clk;
    logic reset;

    y_alu_seq_if #(.WIDTH(32)) bus32();
    y_alu_seq_if #(.WIDTH(8))  bus8();
    y_alu_seq_if #(.WIDTH(8))  busnm();

    y_alu_seq #(.WIDTH(32), .MUL_EN(1'b1)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
    y_alu_seq #(.WIDTH(8),  .MUL_EN(1'b1)) dut8  (.clk(clk), .reset(reset), .bus(bus8));
    y_alu_seq #(.WIDTH(8),  .MUL_EN(1'b0)) dutnm (.clk(clk), .reset(reset), .bus(busnm));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] z;
        logic        zero;
        logic        ovf;
        logic        err;
    } vec_t;

    vec_t vecs [16];

    int cmpCount  = 0;
    int failCount = 0;
    int cyc;
    int seen;
    logic readyLeak;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] rz;
    logic        rop;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmpCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus32.op       = op;
        bus32.a        = a;
        bus32.b        = b;
        bus32.in_valid = 1'b1;
    endtask

    // Issue a 32-bit multiply, keep junk on the input while it iterates, and
    // check latency, in_ready during BUSY and the final result.
    task automatic mulRun(input string name, input logic [31:0] ma, input logic [31:0] mb,
                          input logic [31:0] ez, input logic eovf);
        int n;
        logic leak;
        applyStimulus(3'b100, ma, mb);
        #1;
        checkOutput({name, "_in_ready"}, 64'(bus32.in_ready), 64'd1);
        tick;
        applyStimulus(3'b010, 32'hDEAD_BEEF, 32'h0000_0001);
        n    = 0;
        leak = 1'b0;
        while (!bus32.out_valid && n < 40) begin
            if (bus32.in_ready) leak = 1'b1;
            tick;
            n++;
        end
        bus32.in_valid = 1'b0;
        checkOutput({name, "_latency"}, 64'(n), 64'd32);
        checkOutput({name, "_busy_ready"}, 64'(leak), 64'd0);
        checkOutput({name, "_z"}, 64'(bus32.z), 64'(ez));
        checkOutput({name, "_zero"}, 64'(bus32.zero), 64'(ez == 32'd0));
        checkOutput({name, "_ovf"}, 64'(bus32.ovf), 64'(eovf));
        checkOutput({name, "_err"}, 64'(bus32.err), 64'd0);
        tick;
        checkOutput({name, "_consumed"}, 64'(bus32.out_valid), 64'd0);
    endtask

    initial begin
        vecs[0]  = '{3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{3'b110, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{3'b111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{3'b011, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{3'b000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{3'b001, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{3'b110, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{3'b010, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{3'b110, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{3'b110, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{3'b111, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{3'b011, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{3'b101, 32'h0000_007B, 32'h0000_01C8, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[14] = '{3'b111, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{3'b010, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0, 1'b0};

        reset = 1'b1;
        bus32.in_valid = 1'b0; bus32.out_ready = 1'b0; bus32.a = '0; bus32.b = '0; bus32.op = '0;
        bus8.in_valid  = 1'b0; bus8.out_ready  = 1'b0; bus8.a  = '0; bus8.b  = '0; bus8.op  = '0;
        busnm.in_valid = 1'b0; busnm.out_ready = 1'b0; busnm.a = '0; busnm.b = '0; busnm.op = '0;

        // Reset, then idle with nothing offered.
        tick;
        tick;
        checkOutput("rst_in_ready", 64'(bus32.in_ready), 64'd1);
        checkOutput("rst_out_valid", 64'(bus32.out_valid), 64'd0);
        checkOutput("rst_z", 64'(bus32.z), 64'd0);
        checkOutput("rst_zero", 64'(bus32.zero), 64'd0);
        checkOutput("rst_ovf", 64'(bus32.ovf), 64'd0);
        checkOutput("rst_err", 64'(bus32.err), 64'd0);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (bus32.out_valid) seen++;
        end
        checkOutput("idle_no_output", 64'(seen), 64'd0);

        // Directed vectors streamed one per cycle.
        bus32.out_ready = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
            checkOutput($sformatf("vec%0d_in_ready", i), 64'(bus32.in_ready), 64'd1);
            tick;
            checkOutput($sformatf("vec%0d_valid", i), 64'(bus32.out_valid), 64'd1);
            checkOutput($sformatf("vec%0d_z", i), 64'(bus32.z), 64'(vecs[i].z));
            checkOutput($sformatf("vec%0d_zero", i), 64'(bus32.zero), 64'(vecs[i].zero));
            checkOutput($sformatf("vec%0d_ovf", i), 64'(bus32.ovf), 64'(vecs[i].ovf));
            checkOutput($sformatf("vec%0d_err", i), 64'(bus32.err), 64'(vecs[i].err));
        end
        bus32.in_valid = 1'b0;
        tick;
        checkOutput("stream_drained", 64'(bus32.out_valid), 64'd0);

        // Random AND/OR against a software model, one result per cycle.
        for (int i = 0; i < 200; i++) begin
            ra  = $urandom;
            rb  = $urandom;
            rop = 1'($urandom_range(0, 1));
            rz  = rop ? (ra | rb) : (ra & rb);
            applyStimulus({2'b00, rop}, ra, rb);
            tick;
            checkOutput($sformatf("rnd%0d_z", i), 64'(bus32.z), 64'(rz));
            checkOutput($sformatf("rnd%0d_zero", i), 64'(bus32.zero), 64'(rz == 32'd0));
        end
        bus32.in_valid = 1'b0;
        tick;

        // Multiply from IDLE.
        mulRun("mul_pow", 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);
        mulRun("mul_small", 32'd1234, 32'd5678, 32'd7006652, 1'b0);
        mulRun("mul_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);

        // Backpressure: ADD result held while a SUB waits at the input.
        bus32.out_ready = 1'b0;
        applyStimulus(3'b010, 32'd3, 32'd4);
        tick;
        applyStimulus(3'b110, 32'd10, 32'd3);
        readyLeak = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus32.in_ready) readyLeak = 1'b1;
            if (bus32.out_valid && bus32.z == 32'd7 && !bus32.zero && !bus32.ovf && !bus32.err) seen++;
            tick;
        end
        checkOutput("bp_held", 64'(seen), 64'd5);
        checkOutput("bp_ready_low", 64'(readyLeak), 64'd0);
        bus32.out_ready = 1'b1;
        #1;
        checkOutput("bp_release_ready", 64'(bus32.in_ready), 64'd1);
        tick;
        checkOutput("bp_next_valid", 64'(bus32.out_valid), 64'd1);
        checkOutput("bp_next_z", 64'(bus32.z), 64'd7);
        // Multiply accepted straight out of DONE while that result is consumed.
        mulRun("mul_from_done", 32'd7, 32'd9, 32'd63, 1'b0);

        // Multiply disabled: op 100 behaves as illegal.
        busnm.out_ready = 1'b1;
        busnm.op = 3'b100; busnm.a = 8'h03; busnm.b = 8'h05; busnm.in_valid = 1'b1;
        tick;
        busnm.in_valid = 1'b0;
        checkOutput("nomul_valid", 64'(busnm.out_valid), 64'd1);
        checkOutput("nomul_z", 64'(busnm.z), 64'd0);
        checkOutput("nomul_zero", 64'(busnm.zero), 64'd1);
        checkOutput("nomul_err", 64'(busnm.err), 64'd1);
        checkOutput("nomul_ovf", 64'(busnm.ovf), 64'd0);
        tick;

        // 8-bit multiply.
        bus8.out_ready = 1'b1;
        bus8.op = 3'b100; bus8.a = 8'h0F; bus8.b = 8'h11; bus8.in_valid = 1'b1;
        tick;
        bus8.in_valid = 1'b0;
        cyc = 0;
        while (!bus8.out_valid && cyc < 20) begin
            tick;
            cyc++;
        end
        checkOutput("mul8_latency", 64'(cyc), 64'd8);
        checkOutput("mul8_z", 64'(bus8.z), 64'hFF);
        checkOutput("mul8_ovf", 64'(bus8.ovf), 64'd0);
        checkOutput("mul8_zero", 64'(bus8.zero), 64'd0);
        tick;

        // Reset in the third BUSY cycle abandons the multiply.
        bus8.op = 3'b100; bus8.a = 8'h0F; bus8.b = 8'h11; bus8.in_valid = 1'b1;
        tick;
        bus8.in_valid = 1'b0;
        tick;
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        checkOutput("rst8_out_valid", 64'(bus8.out_valid), 64'd0);
        checkOutput("rst8_in_ready", 64'(bus8.in_ready), 64'd1);
        checkOutput("rst8_z", 64'(bus8.z), 64'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (bus8.out_valid) seen++;
        end
        checkOutput("rst8_no_output", 64'(seen), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
        $finish;
    end

endmodule
